// File: rtl/vram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vram_arbiter_if                                                 |
// | Purpose  : Display, client and RAM-macro signals of the VRAM arbiter.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface vram_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 11,
    parameter int DATA_W      = 8
);
    logic                          video_on;
    logic                          disp_req;
    logic [ADDR_W-1:0]             disp_addr;
    logic                          disp_rvalid;
    logic [DATA_W-1:0]             disp_rdata;
    logic [NUM_CLIENTS-1:0]        cli_req;
    logic [NUM_CLIENTS-1:0]        cli_we;
    logic [NUM_CLIENTS*ADDR_W-1:0] cli_addr;
    logic [NUM_CLIENTS*DATA_W-1:0] cli_wdata;
    logic [NUM_CLIENTS-1:0]        cli_gnt;
    logic [NUM_CLIENTS-1:0]        cli_rvalid;
    logic [DATA_W-1:0]             cli_rdata;
    logic                          ram_en;
    logic                          ram_we;
    logic [ADDR_W-1:0]             ram_addr;
    logic [DATA_W-1:0]             ram_wdata;
    logic [DATA_W-1:0]             ram_rdata;

    // Arbiter side.
    modport slave (
        input  video_on, disp_req, disp_addr, cli_req, cli_we, cli_addr, cli_wdata, ram_rdata,
        output disp_rvalid, disp_rdata, cli_gnt, cli_rvalid, cli_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata
    );

    // Requester / RAM-macro side.
    modport master (
        output video_on, disp_req, disp_addr, cli_req, cli_we, cli_addr, cli_wdata, ram_rdata,
        input  disp_rvalid, disp_rdata, cli_gnt, cli_rvalid, cli_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vram_arbiter                                                    |
// | Purpose  : Single-port VRAM arbiter, display first, round-robin clients.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vram_arbiter #(
    parameter int NUM_CLIENTS  = 2,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 8,
    parameter int BLANK_WRITES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    vram_arbiter_if.slave    bus
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic c_blank = (BLANK_WRITES != 0);

    logic [NUM_CLIENTS-1:0] w_elig;
    logic [IDX_W:0]         w_sum;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_win;
    logic                   w_found;
    logic                   w_cli_win;
    logic [IDX_W-1:0]       w_next_ptr;
    logic                   w_sel_we;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;

    logic [IDX_W-1:0]       r_rr_ptr;
    logic                   r_ram_en;
    logic                   r_ram_we;
    logic [ADDR_W-1:0]      r_ram_addr;
    logic [DATA_W-1:0]      r_ram_wdata;
    logic                   r_iss_disp;
    logic                   r_iss_cli;
    logic [IDX_W-1:0]       r_iss_idx;
    logic                   r_ret_disp;
    logic                   r_ret_cli;
    logic [IDX_W-1:0]       r_ret_idx;

    // Writes during the visible area would tear the picture, so hold them off.
    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_elig
        assign w_elig[i] = bus.cli_req[i] & ~(c_blank & bus.cli_we[i] & bus.video_on);
    end

    always_comb begin
        w_sum   = '0;
        w_cand  = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_CLIENTS))
                w_sum = w_sum - (IDX_W+1)'(NUM_CLIENTS);
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_cli_win   = ~bus.disp_req & w_found;
    assign w_next_ptr  = (w_win == IDX_W'(NUM_CLIENTS-1)) ? '0 : w_win + 1'b1;
    assign w_sel_we    = bus.cli_we[w_win];
    assign w_sel_addr  = bus.cli_addr[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_sel_wdata = bus.cli_wdata[int'(w_win)*DATA_W +: DATA_W];

    assign bus.cli_gnt = w_cli_win ? (NUM_CLIENTS'(1) << w_win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_iss_disp  <= 1'b0;
            r_iss_cli   <= 1'b0;
            r_iss_idx   <= '0;
            r_ret_disp  <= 1'b0;
            r_ret_cli   <= 1'b0;
            r_ret_idx   <= '0;
        end else begin
            r_ram_en   <= bus.disp_req | w_cli_win;
            r_iss_disp <= bus.disp_req;
            r_iss_cli  <= w_cli_win;
            r_iss_idx  <= w_win;
            if (bus.disp_req) begin
                r_ram_we   <= 1'b0;
                r_ram_addr <= bus.disp_addr;
            end else if (w_cli_win) begin
                r_ram_we    <= w_sel_we;
                r_ram_addr  <= w_sel_addr;
                r_ram_wdata <= w_sel_wdata;
                r_rr_ptr    <= w_next_ptr;
            end else begin
                r_ram_we <= 1'b0;
            end
            // The registered write flag doubles as the tag's read/write bit.
            r_ret_disp <= r_iss_disp & ~r_ram_we;
            r_ret_cli  <= r_iss_cli & ~r_ram_we;
            r_ret_idx  <= r_iss_idx;
        end
    end

    assign bus.ram_en      = r_ram_en;
    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.disp_rvalid = r_ret_disp;
    assign bus.disp_rdata  = bus.ram_rdata;
    assign bus.cli_rvalid  = r_ret_cli ? (NUM_CLIENTS'(1) << r_ret_idx) : '0;
    assign bus.cli_rdata   = bus.ram_rdata;
endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vram_arbiter                                                 |
// | Purpose  : Directed + random bench for vram_arbiter against a txn model.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vram_arbiter;
    localparam int N    = 2;
    localparam int AW   = 11;
    localparam int DW   = 8;
    localparam int MAXC = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
    vram_arbiter #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .BLANK_WRITES(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM macro: one-cycle synchronous read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic          ram_load = 1'b1;
    assign bus.ram_rdata = ram_q;
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < (1<<AW); i++) mem[i] <= DW'(i) ^ 8'h48;
        end else if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else            ram_q <= mem[bus.ram_addr];
        end
    end

    // Stimulus state (clients hold a request until the model grants it).
    logic          d_req;
    logic [AW-1:0] d_addr;
    logic          vo;
    logic [N-1:0]  p_req, p_we;
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];

    // Reference: memory contents as seen by accepted transactions, and the
    // expected observation per cycle number.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_ptr;
    logic          exp_en  [MAXC];
    logic          exp_we  [MAXC];
    logic [AW-1:0] exp_adr [MAXC];
    logic [DW-1:0] exp_wd  [MAXC];
    logic          exp_dv  [MAXC];
    logic [N-1:0]  exp_cv  [MAXC];
    logic [DW-1:0] exp_dat [MAXC];
    int            cyc;
    int            n_total = 0;
    int            n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic r);
        int t, w, idx;
        logic [N-1:0]    g;
        logic [N*AW-1:0] ca;
        logic [N*DW-1:0] cw;
        t = cyc;
        for (int i = 0; i < N; i++) begin
            ca[i*AW +: AW] = p_addr[i];
            cw[i*DW +: DW] = p_wd[i];
        end
        rst           = r;
        bus.video_on  = vo;
        bus.disp_req  = d_req;
        bus.disp_addr = d_addr;
        bus.cli_req   = p_req;
        bus.cli_we    = p_we;
        bus.cli_addr  = ca;
        bus.cli_wdata = cw;
        @(negedge clk);
        w = -1;
        if (!d_req)
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && p_req[idx] && !(p_we[idx] && vo)) w = idx;
            end
        g = (w >= 0) ? N'(1) << w : '0;
        check("cli_gnt", bus.cli_gnt, g);
        check("ram_en", bus.ram_en, exp_en[t]);
        if (exp_en[t]) begin
            check("ram_we", bus.ram_we, exp_we[t]);
            check("ram_addr", bus.ram_addr, exp_adr[t]);
            if (exp_we[t]) check("ram_wdata", bus.ram_wdata, exp_wd[t]);
        end else begin
            check("ram_we_idle", bus.ram_we, 1'b0);
        end
        check("disp_rvalid", bus.disp_rvalid, exp_dv[t]);
        check("cli_rvalid", bus.cli_rvalid, exp_cv[t]);
        if (exp_dv[t])      check("disp_rdata", bus.disp_rdata, exp_dat[t]);
        if (exp_cv[t] != 0) check("cli_rdata", bus.cli_rdata, exp_dat[t]);
        if (r) begin
            exp_en[t+1] = 0; exp_dv[t+1] = 0; exp_cv[t+1] = '0;
            exp_en[t+2] = 0; exp_dv[t+2] = 0; exp_cv[t+2] = '0;
            m_ptr = 0;
        end else if (d_req) begin
            exp_en[t+1] = 1; exp_we[t+1] = 0; exp_adr[t+1] = d_addr;
            exp_dv[t+2] = 1; exp_dat[t+2] = ref_mem[d_addr];
        end else if (w >= 0) begin
            exp_en[t+1] = 1; exp_we[t+1] = p_we[w];
            exp_adr[t+1] = p_addr[w]; exp_wd[t+1] = p_wd[w];
            if (p_we[w]) ref_mem[p_addr[w]] = p_wd[w];
            else begin
                exp_cv[t+2]  = N'(1) << w;
                exp_dat[t+2] = ref_mem[p_addr[w]];
            end
            m_ptr    = (w + 1) % N;
            p_req[w] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        d_req = 0; p_req = '0;
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic cli(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[i] = 1'b1; p_we[i] = we; p_addr[i] = a; p_wd[i] = d;
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = DW'(i) ^ 8'h48;
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i] = 0; exp_we[i] = 0; exp_adr[i] = '0; exp_wd[i] = '0;
            exp_dv[i] = 0; exp_cv[i] = '0; exp_dat[i] = '0;
        end
        cyc = 0; m_ptr = 0;
        d_req = 0; d_addr = '0; vo = 0; p_req = '0; p_we = '0;
        for (int i = 0; i < N; i++) begin p_addr[i] = '0; p_wd[i] = '0; end

        step(1'b1); step(1'b1); step(1'b1);
        ram_load = 1'b0;
        check("rst_ram_addr", bus.ram_addr, '0);
        check("rst_ram_wdata", bus.ram_wdata, '0);
        check("rst_ram_en", bus.ram_en, 1'b0);

        // Display read of 0x012 (holds 0x5A).
        d_req = 1; d_addr = 11'h012; step(1'b0);
        idle(3);

        // Display beats both clients for 3 cycles, then they alternate.
        cli(0, 0, 11'h005, 0); cli(1, 0, 11'h006, 0);
        d_req = 1; d_addr = 11'h001;
        step(1'b0); step(1'b0); step(1'b0);
        d_req = 0;
        step(1'b0); step(1'b0);
        cli(0, 0, 11'h007, 0); cli(1, 0, 11'h008, 0);
        step(1'b0); step(1'b0);
        idle(2);

        // Write held off during the visible area, then read back by client 1.
        vo = 1; cli(0, 1, 11'h100, 8'h07);
        step(1'b0); step(1'b0); step(1'b0);
        vo = 0; step(1'b0);
        cli(1, 0, 11'h100, 0); step(1'b0);
        idle(3);

        // Reads are served during the visible area.
        vo = 1; cli(1, 0, 11'h020, 0); step(1'b0);
        idle(3); vo = 0;

        // Reset right after a read grant drops the read; client 0 wins after.
        cli(1, 0, 11'h030, 0); step(1'b0);
        p_req = '0; step(1'b1);
        idle(2);
        cli(0, 0, 11'h031, 0); cli(1, 0, 11'h032, 0);
        step(1'b0); step(1'b0);
        idle(2);

        // Client 0 withdraws during a display burst.
        d_req = 1; d_addr = 11'h040; cli(0, 0, 11'h041, 0);
        step(1'b0); step(1'b0);
        p_req[0] = 0; step(1'b0);
        idle(1);
        cli(0, 0, 11'h042, 0); cli(1, 0, 11'h043, 0);
        step(1'b0); step(1'b0);
        idle(2);

        for (int n = 0; n < 1500; n++) begin
            logic r;
            if ($urandom_range(0, 15) == 0) vo = ~vo;
            d_req  = ($urandom_range(0, 3) == 0);
            d_addr = AW'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if (!p_req[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        cli(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
                end else if ($urandom_range(0, 19) == 0) begin
                    p_req[i] = 1'b0;
                end
            end
            r = ($urandom_range(0, 199) == 0);
            if (r) begin d_req = 0; p_req = '0; end
            step(r);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
